tx_pattern_gen: RTL



---
 rtl/tx_pattern_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tx_pattern_gen.sv
// tx_pattern_gen: 16-bit transmit test-pattern source.
// Emits a preamble, then PRBS7/PRBS31/fixed/clock words.
// Ports: clk, rst_n (async, low), en, mode[1:0], pat_word[15:0],
//   inj_error (rise flips dout[0] of one RUN word), dout[15:0],
//   dout_valid, err_cnt[15:0].
// Macro TX_PATGEN_ERR_CNT_EN builds the err_cnt counter;
//   otherwise err_cnt is tied to zero.
module tx_pattern_gen #(
  parameter int          TRAIN_WORDS = 8,
  parameter logic [6:0]  SEED7       = 7'h7F,
  parameter logic [30:0] SEED31      = 31'h7FFFFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] pat_word,
  input  logic        inj_error,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    RUN
  } state_t;

  state_t      state;
  logic [2:0]  mode_q;
  logic [7:0]  cnt;
  logic [6:0]  lfsr7;
  logic [30:0] lfsr31;
  logic        inj_q;
  logic        inj_pend;

  logic        rise;
  logic        last;
  logic [6:0]  s7;
  logic        b7;
  logic [15:0] w7;
  logic [30:0] s31;
  logic        b31;
  logic [15:0] w31;
  logic [15:0] pat;

  assign rise = inj_error & ~inj_q;
  assign last = (cnt == 8'(TRAIN_WORDS - 1));

  // 16 steps per word. For PRBS31 every tap of
  // the 16 steps is still a current-state bit,
  // so each output bit is a single XOR.
  always_comb begin
    s7 = lfsr7;
    b7 = 1'b0;
    w7 = '0;
    for (int k = 0; k < 16; k++) begin
      b7 = s7[6] ^ s7[5];
      w7[15-k] = b7;
      s7 = {s7[5:0], b7};
    end
  end

  always_comb begin
    s31 = lfsr31;
    b31 = 1'b0;
    w31 = '0;
    for (int k = 0; k < 16; k++) begin
      b31 = s31[30] ^ s31[27];
      w31[15-k] = b31;
      s31 = {s31[29:0], b31};
    end
  end

  always_comb begin
    pat = 16'hAAAA;
    unique case (1'b1)
      (mode_q == 3'd0): pat = w7;
      (mode_q == 3'd1): pat = w31;
      (mode_q == 3'd2): pat = pat_word;
      default:          pat = 16'hAAAA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_q     <= 3'd0;
      cnt        <= 8'd0;
      lfsr7      <= SEED7;
      lfsr31     <= SEED31;
      inj_q      <= 1'b0;
      inj_pend   <= 1'b0;
      dout       <= 16'h0000;
      dout_valid <= 1'b0;
    end else begin
      inj_q    <= inj_error;
      inj_pend <= 1'b0;
      if (!en) begin
        state      <= IDLE;
        lfsr7      <= SEED7;
        lfsr31     <= SEED31;
        dout       <= 16'h0000;
        dout_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state      <= TRAIN;
            mode_q     <= {1'b0, mode};
            cnt        <= 8'd0;
            lfsr7      <= SEED7;
            lfsr31     <= SEED31;
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
          end
          TRAIN: begin
            cnt        <= cnt + 8'd1;
            dout       <= 16'hFF00;
            dout_valid <= 1'b0;
            if (last) state <= RUN;
          end
          RUN: begin
            // A pending rise only ever touches
            // this word; LFSRs step untouched.
            dout       <= pat ^ {15'd0, inj_pend};
            dout_valid <= 1'b1;
            inj_pend   <= rise;
            if (mode_q == 3'd0) lfsr7 <= s7;
            if (mode_q == 3'd1) lfsr31 <= s31;
          end
          default: begin
            state      <= IDLE;
            dout       <= 16'h0000;
            dout_valid <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TX_PATGEN_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  logic        flip;

  assign flip = en & inj_pend & (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'h0000;
    end else if (flip && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'h0000;
`endif

endmodule
